// File: rtl/pagerank_prefix_engine.sv
// One-pass rank prefix engine: streams 16-lane lines over AXI and writes the running prefix sums.
// The 64-bit total is read back at DONE_ALL. Define PR_PERF_CNT_EN to build a cycle counter readable at 0x28.
module pagerank_prefix_engine #(
  parameter logic [63:0] DEFAULT_NV = 64'd64,
  parameter logic [15:0] AXI_ID     = 16'd0
) (
  input  logic         clk,
  input  logic         rst,
  output logic [15:0]  arid_m,
  output logic [63:0]  araddr_m,
  output logic [7:0]   arlen_m,
  output logic [2:0]   arsize_m,
  output logic         arvalid_m,
  input  logic         arready_m,
  input  logic [15:0]  rid_m,
  input  logic [511:0] rdata_m,
  input  logic [1:0]   rresp_m,
  input  logic         rlast_m,
  input  logic         rvalid_m,
  output logic         rready_m,
  output logic [15:0]  awid_m,
  output logic [63:0]  awaddr_m,
  output logic [7:0]   awlen_m,
  output logic [2:0]   awsize_m,
  output logic         awvalid_m,
  input  logic         awready_m,
  output logic [15:0]  wid_m,
  output logic [511:0] wdata_m,
  output logic [63:0]  wstrb_m,
  output logic         wlast_m,
  output logic         wvalid_m,
  input  logic         wready_m,
  input  logic [15:0]  bid_m,
  input  logic [1:0]   bresp_m,
  input  logic         bvalid_m,
  output logic         bready_m,
  input  logic         softreg_req_valid,
  input  logic         softreg_req_isWrite,
  input  logic [31:0]  softreg_req_addr,
  input  logic [63:0]  softreg_req_data,
  output logic         softreg_resp_valid,
  output logic [63:0]  softreg_resp_data
);
  // state  | meaning
  // IDLE   | waiting for a start (write to WRITE_ADDR0)
  // AR     | issuing read address for line i
  // R      | waiting for the read beat, computing prefixes
  // AW_W   | write address and data outstanding
  // B      | waiting for write response
  // DONE   | job finished, raise done flag
  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW_W, S_B, S_DONE} state_t;

  localparam logic [31:0] A_WRITE = 32'h00;
  localparam logic [31:0] A_READ  = 32'h08;
  localparam logic [31:0] A_NV    = 32'h10;
  localparam logic [31:0] A_DONE  = 32'h20;
  localparam logic [31:0] A_PERF  = 32'h28;

  state_t       state;
  logic [63:0]  wr_base, rd_base, n_vertices;
  logic [63:0]  rd_ptr, wr_ptr, rem, sum;
  logic [31:0]  prefix;
  logic         done, pending;
  logic [511:0] lane_out;
  logic [63:0]  strb_nxt, line_sum, rd_data, perf_val;
  logic         start, rd_req, fin, aw_ok, w_ok;
  logic         unused_inputs;

  assign arid_m   = AXI_ID;
  assign awid_m   = AXI_ID;
  assign wid_m    = AXI_ID;
  assign arlen_m  = 8'd0;
  assign awlen_m  = 8'd0;
  assign arsize_m = 3'd6;
  assign awsize_m = 3'd6;
  assign wlast_m  = 1'b1;
  assign araddr_m = rd_ptr;
  assign awaddr_m = wr_ptr;
  assign unused_inputs = ^{rid_m, rresp_m, rlast_m, bid_m, bresp_m};

  assign start  = softreg_req_valid && softreg_req_isWrite && (softreg_req_addr == A_WRITE)
                  && (state == S_IDLE);
  assign rd_req = softreg_req_valid && !softreg_req_isWrite;
  assign fin    = done || (state == S_DONE);
  assign aw_ok  = !awvalid_m || awready_m;
  assign w_ok   = !wvalid_m || wready_m;

  // rem counts elements still owed; lanes at or beyond it are padding
  always_comb begin
    logic [31:0] run;
    logic [31:0] lane;
    run      = prefix;
    lane_out = '0;
    strb_nxt = '0;
    line_sum = '0;
    for (int k = 0; k < 16; k++) begin
      lane = (rem > 64'(k)) ? rdata_m[32*k +: 32] : 32'd0;
      run  = run + lane;
      lane_out[32*k +: 32] = run;
      line_sum = line_sum + 64'(lane);
      if (rem > 64'(k)) strb_nxt[4*k +: 4] = 4'hF;
    end
  end

  always_comb begin
    rd_data = 64'd0;
    case (softreg_req_addr)
      A_WRITE: rd_data = wr_base;
      A_READ:  rd_data = rd_base;
      A_NV:    rd_data = n_vertices;
      A_DONE:  rd_data = sum;
      A_PERF:  rd_data = perf_val;
      default: rd_data = 64'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      wr_base <= '0; rd_base <= '0; n_vertices <= DEFAULT_NV;
      rd_ptr <= '0; wr_ptr <= '0; rem <= '0; sum <= '0; prefix <= '0;
      done <= 1'b1; pending <= 1'b0;
      arvalid_m <= 1'b0; rready_m <= 1'b0; awvalid_m <= 1'b0; wvalid_m <= 1'b0;
      bready_m <= 1'b0; wdata_m <= '0; wstrb_m <= '0;
      softreg_resp_valid <= 1'b0; softreg_resp_data <= '0;
    end else begin
      softreg_resp_valid <= 1'b0;
      if (softreg_req_valid && softreg_req_isWrite && state == S_IDLE) begin
        case (softreg_req_addr)
          A_WRITE: wr_base <= {softreg_req_data[63:6], 6'd0};
          A_READ:  rd_base <= {softreg_req_data[63:6], 6'd0};
          A_NV:    n_vertices <= softreg_req_data;
          default: ;
        endcase
      end
      // a DONE_ALL read while busy parks in pending; a second one is dropped
      if (rd_req) begin
        if (softreg_req_addr == A_DONE && !fin) begin
          pending <= 1'b1;
        end else begin
          softreg_resp_valid <= 1'b1;
          softreg_resp_data  <= rd_data;
          if (softreg_req_addr == A_DONE) pending <= 1'b0;
        end
      end else if (pending && fin) begin
        softreg_resp_valid <= 1'b1;
        softreg_resp_data  <= sum;
        pending <= 1'b0;
      end

      case (state)
        S_IDLE: if (start) begin
          wr_ptr <= {softreg_req_data[63:6], 6'd0};
          rd_ptr <= rd_base;
          rem    <= n_vertices;
          prefix <= '0;
          sum    <= '0;
          done   <= 1'b0;
          if (n_vertices == 64'd0) state <= S_DONE;
          else begin
            state <= S_AR;
            arvalid_m <= 1'b1;
          end
        end
        S_AR: if (arready_m) begin
          arvalid_m <= 1'b0;
          rready_m  <= 1'b1;
          state     <= S_R;
        end
        S_R: if (rvalid_m) begin
          rready_m  <= 1'b0;
          wdata_m   <= lane_out;
          wstrb_m   <= strb_nxt;
          prefix    <= lane_out[511:480];
          sum       <= sum + line_sum;
          awvalid_m <= 1'b1;
          wvalid_m  <= 1'b1;
          state     <= S_AW_W;
        end
        S_AW_W: begin
          if (awvalid_m && awready_m) awvalid_m <= 1'b0;
          if (wvalid_m && wready_m) wvalid_m <= 1'b0;
          if (aw_ok && w_ok) begin
            bready_m <= 1'b1;
            state    <= S_B;
          end
        end
        S_B: if (bvalid_m) begin
          bready_m <= 1'b0;
          rd_ptr   <= rd_ptr + 64'd64;
          wr_ptr   <= wr_ptr + 64'd64;
          if (rem > 64'd16) begin
            rem       <= rem - 64'd16;
            arvalid_m <= 1'b1;
            state     <= S_AR;
          end else begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef PR_PERF_CNT_EN
  logic [63:0] perf_cnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) perf_cnt <= '0;
    else if (start) perf_cnt <= '0;
    else if (state != S_IDLE && state != S_DONE) perf_cnt <= perf_cnt + 64'd1;
  end
  assign perf_val = perf_cnt;
`else
  assign perf_val = 64'd0;
`endif

endmodule

// File: tb/tb_pagerank_prefix_engine.sv
// Directed bench for pagerank_prefix_engine: AXI memory responder that checks every beat
// against an element-level prefix-sum model, plus literal checks on results.
module tb_pagerank_prefix_engine;
  logic         clk, rst;
  logic [15:0]  arid_m, rid_m, awid_m, wid_m, bid_m;
  logic [63:0]  araddr_m, awaddr_m, wstrb_m;
  logic [7:0]   arlen_m, awlen_m;
  logic [2:0]   arsize_m, awsize_m;
  logic         arvalid_m, arready_m, rlast_m, rvalid_m, rready_m;
  logic         awvalid_m, awready_m, wlast_m, wvalid_m, wready_m, bvalid_m, bready_m;
  logic [511:0] rdata_m, wdata_m;
  logic [1:0]   rresp_m, bresp_m;
  logic         softreg_req_valid, softreg_req_isWrite, softreg_resp_valid;
  logic [31:0]  softreg_req_addr;
  logic [63:0]  softreg_req_data, softreg_resp_data;

  pagerank_prefix_engine dut (
    .clk(clk), .rst(rst),
    .arid_m(arid_m), .araddr_m(araddr_m), .arlen_m(arlen_m), .arsize_m(arsize_m),
    .arvalid_m(arvalid_m), .arready_m(arready_m),
    .rid_m(rid_m), .rdata_m(rdata_m), .rresp_m(rresp_m), .rlast_m(rlast_m),
    .rvalid_m(rvalid_m), .rready_m(rready_m),
    .awid_m(awid_m), .awaddr_m(awaddr_m), .awlen_m(awlen_m), .awsize_m(awsize_m),
    .awvalid_m(awvalid_m), .awready_m(awready_m),
    .wid_m(wid_m), .wdata_m(wdata_m), .wstrb_m(wstrb_m), .wlast_m(wlast_m),
    .wvalid_m(wvalid_m), .wready_m(wready_m),
    .bid_m(bid_m), .bresp_m(bresp_m), .bvalid_m(bvalid_m), .bready_m(bready_m),
    .softreg_req_valid(softreg_req_valid), .softreg_req_isWrite(softreg_req_isWrite),
    .softreg_req_addr(softreg_req_addr), .softreg_req_data(softreg_req_data),
    .softreg_resp_valid(softreg_resp_valid), .softreg_resp_data(softreg_resp_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check512(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event not expected or not seen", nm);
  endtask

  // memory and expected transaction queues
  logic [511:0] mem [0:63];
  logic [63:0]  exp_ar[$], exp_aw[$], exp_ws[$];
  logic [511:0] exp_wd[$];

  bit           r_pend = 0, r_hold = 0, aw_active = 0, aw_got = 0, w_got = 0;
  logic [63:0]  r_addr, aw_addr, w_strb, last_ws;
  logic [511:0] w_data;
  int aw_cnt = 0, aw_stall = 0, aw_hi = 0, w_hi = 0, last_aw_hi = 0, last_w_hi = 0;
  int ar_cnt = 0, aw_tx = 0, b_cnt = 0, bad_b = 0;

  // prefix model at element granularity: element j lives at line ra/64 + j/16, lane j%16
  task automatic model(input logic [63:0] ra, input logic [63:0] wa, input logic [63:0] nv,
                       output logic [63:0] tot);
    logic [31:0]  run, x;
    logic [511:0] d;
    logic [63:0]  s;
    int lines, j;
    run = '0;
    tot = '0;
    lines = int'((nv + 64'd15) / 64'd16);
    for (int i = 0; i < lines; i++) begin
      d = '0;
      s = '0;
      exp_ar.push_back(ra + 64'(64 * i));
      exp_aw.push_back(wa + 64'(64 * i));
      for (int k = 0; k < 16; k++) begin
        j = 16 * i + k;
        if (64'(j) < nv) begin
          x = mem[int'(ra[11:6]) + j / 16][32 * (j % 16) +: 32];
          run = run + x;
          tot = tot + 64'(x);
          d[32*k +: 32] = run;
          s[4*k +: 4] = 4'hF;
        end
      end
      exp_wd.push_back(d);
      exp_ws.push_back(s);
    end
  endtask

  // AXI memory responder and per-beat compare
  initial begin
    logic [511:0] m;
    arready_m = 0; rvalid_m = 0; rdata_m = '0; rid_m = '0; rresp_m = '0; rlast_m = 0;
    awready_m = 0; wready_m = 0; bvalid_m = 0; bid_m = '0; bresp_m = '0;
    forever begin
      @(negedge clk);
      rvalid_m = 0; rlast_m = 0; bvalid_m = 0; arready_m = 0; awready_m = 0; wready_m = 0;
      if (!rst) begin
        r_pend = 0; aw_active = 0; aw_got = 0; w_got = 0; aw_hi = 0; w_hi = 0;
      end else begin
        if (bready_m && (aw_active || awvalid_m)) bad_b++;
        if (aw_got && w_got && bready_m) begin
          bvalid_m = 1; b_cnt++;
          for (int b = 0; b < 64; b++)
            if (w_strb[b]) mem[aw_addr[11:6]][8*b +: 8] = w_data[8*b +: 8];
          aw_got = 0; w_got = 0;
        end
        if (r_pend && rready_m && !r_hold) begin
          rvalid_m = 1; rlast_m = 1; rdata_m = mem[r_addr[11:6]]; r_pend = 0;
        end
        if (arvalid_m) begin
          arready_m = 1; ar_cnt++; r_pend = 1; r_addr = araddr_m;
          if (exp_ar.size() == 0) fail_now("ar_unexpected");
          else check("araddr", araddr_m, exp_ar.pop_front());
          check("arlen_arsize", 64'({arlen_m, arsize_m}), 64'({8'd0, 3'd6}));
        end
        if (awvalid_m) begin
          aw_hi++;
          if (!aw_active) begin aw_active = 1; aw_cnt = aw_stall; end
          if (aw_cnt == 0) begin
            awready_m = 1; aw_active = 0; aw_got = 1; aw_addr = awaddr_m; aw_tx++;
            last_aw_hi = aw_hi; aw_hi = 0;
            if (exp_aw.size() == 0) fail_now("aw_unexpected");
            else check("awaddr", awaddr_m, exp_aw.pop_front());
            check("awlen_awsize", 64'({awlen_m, awsize_m}), 64'({8'd0, 3'd6}));
          end else aw_cnt--;
        end
        if (wvalid_m) begin
          w_hi++; wready_m = 1; w_got = 1; w_data = wdata_m; w_strb = wstrb_m; last_ws = wstrb_m;
          last_w_hi = w_hi; w_hi = 0;
          check("wlast", 64'(wlast_m), 64'd1);
          if (exp_wd.size() == 0) fail_now("w_unexpected");
          else begin
            check("wstrb", wstrb_m, exp_ws[0]);
            for (int b = 0; b < 64; b++) m[8*b +: 8] = {8{exp_ws[0][b]}};
            check512("wdata", wdata_m & m, exp_wd[0] & m);
            void'(exp_wd.pop_front());
            void'(exp_ws.pop_front());
          end
        end
      end
    end
  end

  task automatic sr_write(input logic [31:0] a, input logic [63:0] d);
    @(negedge clk);
    softreg_req_valid = 1; softreg_req_isWrite = 1; softreg_req_addr = a; softreg_req_data = d;
    @(negedge clk);
    softreg_req_valid = 0; softreg_req_isWrite = 0;
  endtask

  task automatic sr_read(input logic [31:0] a, input logic [63:0] e, input string nm);
    @(negedge clk);
    softreg_req_valid = 1; softreg_req_isWrite = 0; softreg_req_addr = a;
    @(negedge clk);
    softreg_req_valid = 0;
    check({nm, "_vld"}, 64'(softreg_resp_valid), 64'd1);
    check(nm, softreg_resp_data, e);
  endtask

  task automatic wait_b(input int target);
    for (int k = 0; k < 3000; k++) begin
      if (b_cnt >= target) break;
      @(negedge clk);
    end
    if (b_cnt < target) fail_now("b_timeout");
    repeat (4) @(negedge clk);
  endtask

  task automatic run_job(input logic [63:0] ra, input logic [63:0] wa, input logic [63:0] nv,
                         input bit set_nv, output logic [63:0] tot);
    int target;
    model(ra, wa, nv, tot);
    target = b_cnt + int'((nv + 64'd15) / 64'd16);
    sr_write(32'h08, ra);
    if (set_nv) sr_write(32'h10, nv);
    sr_write(32'h00, wa);
    wait_b(target);
    check("queues_drained", 64'(exp_ar.size() + exp_aw.size() + exp_wd.size()), 64'd0);
    sr_read(32'h20, tot, "done_all");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] tot;
    int ar0, aw0, target, resp_n, b_at;
    logic [63:0] resp_d;
    rst = 0;
    softreg_req_valid = 0; softreg_req_isWrite = 0; softreg_req_addr = '0; softreg_req_data = '0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    @(negedge clk);
    check("rst_valids", 64'({arvalid_m, rready_m, awvalid_m, wvalid_m, bready_m, softreg_resp_valid}), 64'd0);
    check("rst_resp_data", softreg_resp_data, 64'd0);
    @(negedge clk);
    rst = 1;

    sr_read(32'h10, 64'd64, "nv_reset");
    sr_read(32'h00, 64'd0, "waddr_reset");
    sr_read(32'h08, 64'd0, "raddr_reset");
    sr_read(32'h18, 64'd0, "unmapped");
    sr_read(32'h20, 64'd0, "done_all_reset");

    // 64 ones, default N_VERTICES
    for (int l = 0; l < 4; l++) for (int k = 0; k < 16; k++) mem[l][32*k +: 32] = 32'd1;
    run_job(64'd0, 64'd256, 64'd64, 1'b0, tot);
    check("sum_ones", tot, 64'd64);
    check("line4_lane0", 64'(mem[4][31:0]), 64'd1);
    check("line4_lane15", 64'(mem[4][511:480]), 64'd16);
    check("line7_lane15", 64'(mem[7][511:480]), 64'd64);

    // N=20, value 2: partial second line
    for (int l = 0; l < 2; l++) for (int k = 0; k < 16; k++) mem[l][32*k +: 32] = 32'd2;
    run_job(64'd0, 64'd1024, 64'd20, 1'b1, tot);
    check("sum_twos", tot, 64'd40);
    check("partial_strb", last_ws, 64'h0000_0000_0000_FFFF);
    check("line17_lane3", 64'(mem[17][127:96]), 64'd40);

    // DONE_ALL read issued right after start; 32-bit prefix wraps, 64-bit sum does not
    for (int k = 0; k < 16; k++) begin
      mem[0][32*k +: 32] = 32'hF000_0000 + 32'(k);
      mem[1][32*k +: 32] = 32'hF000_0010 + 32'(k);
    end
    model(64'd0, 64'd2048, 64'd32, tot);
    check("sum_wrap_model", tot, 64'h0000_001E_0000_01F0);
    target = b_cnt + 2;
    sr_write(32'h10, 64'd32);
    sr_write(32'h00, 64'd2048);
    @(negedge clk);
    softreg_req_valid = 1; softreg_req_isWrite = 0; softreg_req_addr = 32'h20;
    @(negedge clk);
    softreg_req_valid = 0;
    resp_n = 0; b_at = -1; resp_d = '0;
    for (int k = 0; k < 400; k++) begin
      if (softreg_resp_valid) begin resp_n++; b_at = b_cnt; resp_d = softreg_resp_data; end
      @(negedge clk);
    end
    check("pending_pulses", 64'(resp_n), 64'd1);
    check("pending_after_b", 64'(b_at), 64'(target));
    check("pending_data", resp_d, tot);
    check("line33_lane15", 64'(mem[33][511:480]), 64'h1F0);

    // N=0: no traffic
    ar0 = ar_cnt; aw0 = aw_tx;
    sr_write(32'h10, 64'd0);
    sr_write(32'h00, 64'd256);
    repeat (10) @(negedge clk);
    check("n0_no_ar", 64'(ar_cnt), 64'(ar0));
    check("n0_no_aw", 64'(aw_tx), 64'(aw0));
    sr_read(32'h20, 64'd0, "n0_done_all");

    // awready stalled 5 cycles
    for (int k = 0; k < 16; k++) mem[0][32*k +: 32] = 32'(5 * k + 1);
    aw_stall = 5;
    run_job(64'd0, 64'd3072, 64'd16, 1'b1, tot);
    aw_stall = 0;
    check("stall_sum", tot, 64'd616);
    check("stall_w_cycles", 64'(last_w_hi), 64'd1);
    check("stall_aw_cycles", 64'(last_aw_hi), 64'd6);
    check("stall_b_early", 64'(bad_b), 64'd0);
    check("line48_lane15", 64'(mem[48][511:480]), 64'd616);

    // async reset while in R
    r_hold = 1;
    exp_ar.push_back(64'd0);
    sr_write(32'h10, 64'd64);
    sr_write(32'h00, 64'd256);
    for (int k = 0; k < 50; k++) begin
      if (rready_m) break;
      @(negedge clk);
    end
    check("reached_r", 64'(rready_m), 64'd1);
    #2 rst = 0;
    #1 check("async_rst_valids",
             64'({arvalid_m, rready_m, awvalid_m, wvalid_m, bready_m, softreg_resp_valid}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1; r_hold = 0;
    exp_ar.delete(); exp_aw.delete(); exp_wd.delete(); exp_ws.delete();
    sr_read(32'h10, 64'd64, "nv_after_rst");
    sr_read(32'h00, 64'd0, "waddr_after_rst");
    sr_read(32'h20, 64'd0, "done_all_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
